// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-address generator: FSM encoding, control
// constants and the log2 helper used to size the alignment check.
package pc_gen_pkg;

    typedef enum logic {
        PC_BOOT = 1'b0,
        PC_RUN  = 1'b1
    } pc_state_e;

    localparam logic Branch      = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic FlushEnable = 1'b1;

    // Smallest r with 2**r >= n; used at elaboration time only.
    function automatic int unsigned pc_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_pend_buf.sv
// One-entry pending-branch buffer: remembers a branch resolved while fetch is
// stalled so it can be applied once the stall releases.
module pc_pend_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    // Flush beats set; a new set overwrites an older entry.
    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (set_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: boots at RESET_PC, then steps sequentially or
// redirects on flush, branch or a buffered branch from a stalled cycle.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              INST_BYTES = 4,
    parameter int              STALL_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    output logic               ce,
    output logic [ADDR_W-1:0]  pc,
    output logic               pend_valid_o,
    output logic               misaligned_o
);

    localparam int unsigned AlignBits = pc_log2(INST_BYTES);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_set, pend_clr, pend_flush;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              fetch_stall;

    assign fetch_stall = stall[0];

    // Only the fetch-stage stall bit matters to this block.
    generate
        if (STALL_W > 1) begin : g_unused_stall
            logic unused_stall;
            assign unused_stall = ^stall[STALL_W-1:1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= PC_BOOT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == PC_BOOT) state_d = PC_RUN;
    end

    always_comb begin
        ce = (state_q == PC_RUN) ? ChipEnable : ChipDisable;
    end

    // Redirect priority: flush, stall (buffer a branch), live branch, pending branch, step.
    always_comb begin
        pc_d       = pc_q;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        pend_flush = 1'b0;
        if (state_q == PC_RUN) begin
            if (flush_i == FlushEnable) begin
                pc_d       = new_pc_i;
                pend_flush = 1'b1;
            end else if (fetch_stall != NoStop) begin
                pend_set = (branch_flag_i == Branch);
            end else if (branch_flag_i == Branch) begin
                pc_d     = branch_target_address_i;
                pend_clr = 1'b1;
            end else if (pend_valid) begin
                pc_d     = pend_addr;
                pend_clr = 1'b1;
            end else begin
                pc_d = pc_q + ADDR_W'(INST_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    pc_pend_buf #(
        .ADDR_W (ADDR_W)
    ) u_pend_buf (
        .clk     (clk),
        .rst_n   (rst),
        .set_i   (pend_set),
        .clr_i   (pend_clr),
        .flush_i (pend_flush),
        .addr_i  (branch_target_address_i),
        .valid_o (pend_valid),
        .addr_o  (pend_addr)
    );

    assign pc           = pc_q;
    assign pend_valid_o = pend_valid;

    generate
        if (AlignBits == 0) begin : g_no_align
            assign misaligned_o = 1'b0;
        end else begin : g_align
            assign misaligned_o = ce & (|pc_q[AlignBits-1:0]);
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus a randomized run, all compared
// against a cycle-level behavioural model of the fetch-address rules.
module tb_pc_gen;

    localparam int          ADDR_W     = 32;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int          INST_BYTES = 4;
    localparam int          STALL_W    = 6;

    logic               clk;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic               flush_i;
    logic [ADDR_W-1:0]  new_pc_i;
    logic               ce;
    logic [ADDR_W-1:0]  pc;
    logic               pend_valid_o;
    logic               misaligned_o;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic              m_ce;
    logic [31:0]       m_pc;
    logic              m_pv;
    logic [31:0]       m_pa;

    pc_gen #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (RESET_PC),
        .INST_BYTES (INST_BYTES),
        .STALL_W    (STALL_W)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .flush_i                 (flush_i),
        .new_pc_i                (new_pc_i),
        .ce                      (ce),
        .pc                      (pc),
        .pend_valid_o            (pend_valid_o),
        .misaligned_o            (misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_ce = 1'b0;
        m_pc = RESET_PC;
        m_pv = 1'b0;
        m_pa = '0;
    endtask

    // One rising edge of the specification's rules, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (!m_ce) begin
            m_ce = 1'b1;
        end else if (flush_i) begin
            m_pc = new_pc_i;
            m_pv = 1'b0;
        end else if (stall[0]) begin
            if (branch_flag_i) begin
                m_pv = 1'b1;
                m_pa = branch_target_address_i;
            end
        end else if (branch_flag_i) begin
            m_pc = branch_target_address_i;
            m_pv = 1'b0;
        end else if (m_pv) begin
            m_pc = m_pa;
            m_pv = 1'b0;
        end else begin
            m_pc = m_pc + INST_BYTES;
        end
        #1;
    endtask

    task automatic idle_inputs();
        stall                   = '0;
        branch_flag_i           = 1'b0;
        branch_target_address_i = '0;
        flush_i                 = 1'b0;
        new_pc_i                = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (3) step();
        checks++;
        if (ce !== 1'b0 || pc !== 32'h0 || pend_valid_o !== 1'b0 || misaligned_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ce=%b pc=%h pend=%b mis=%b, want ce=0 pc=0 pend=0 mis=0",
                     ce, pc, pend_valid_o, misaligned_o);
        end
        rst = 1'b1;
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 32'h0) begin
            failures++;
            $display("FAIL boot_edge1: ce=%b pc=%h, want ce=1 pc=00000000", ce, pc);
        end
        step();
        checks++;
        if (pc !== 32'h4) begin
            failures++;
            $display("FAIL boot_edge2: pc=%h, want 00000004", pc);
        end
        step();
        checks++;
        if (pc !== 32'h8) begin
            failures++;
            $display("FAIL boot_edge3: pc=%h, want 00000008", pc);
        end
    endtask

    task automatic test_branch();
        flush_i = 1'b1; new_pc_i = 32'h10;
        step();
        idle_inputs();
        branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h100) begin
            failures++;
            $display("FAIL branch_taken: pc=%h, want 00000100", pc);
        end
        step();
        checks++;
        if (pc !== 32'h104) begin
            failures++;
            $display("FAIL branch_next: pc=%h, want 00000104", pc);
        end
    endtask

    task automatic test_stall_branch();
        flush_i = 1'b1; new_pc_i = 32'h20;
        step();
        idle_inputs();
        stall = 6'b000001;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
        step();
        branch_flag_i = 1'b0; branch_target_address_i = 32'hDEAD_BEE0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pc !== 32'h20 || pend_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: pc=%h pend=%b, want pc=00000020 pend=1", i, pc, pend_valid_o);
            end
            step();
        end
        idle_inputs();
        step();
        checks++;
        if (pc !== 32'h200 || pend_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_apply: pc=%h pend=%b, want pc=00000200 pend=0", pc, pend_valid_o);
        end
        step();
        checks++;
        if (pc !== 32'h204) begin
            failures++;
            $display("FAIL stall_after: pc=%h, want 00000204", pc);
        end
    endtask

    task automatic test_flush_priority();
        stall = 6'b000001;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
        step();
        flush_i = 1'b1; new_pc_i = 32'h380;
        branch_target_address_i = 32'h400;
        step();
        checks++;
        if (pc !== 32'h380 || pend_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_prio: pc=%h pend=%b, want pc=00000380 pend=0", pc, pend_valid_o);
        end
        idle_inputs();
        step();
        checks++;
        if (pc !== 32'h384) begin
            failures++;
            $display("FAIL flush_release: pc=%h, want 00000384", pc);
        end
    endtask

    task automatic test_wrap_misalign();
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        checks++;
        if (pc !== 32'h0 || misaligned_o !== 1'b0) begin
            failures++;
            $display("FAIL wrap: pc=%h mis=%b, want pc=00000000 mis=0", pc, misaligned_o);
        end
        branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h102 || misaligned_o !== 1'b1) begin
            failures++;
            $display("FAIL misalign_load: pc=%h mis=%b, want pc=00000102 mis=1", pc, misaligned_o);
        end
        step();
        checks++;
        if (pc !== 32'h106) begin
            failures++;
            $display("FAIL misalign_step: pc=%h, want 00000106", pc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall                   = STALL_W'($urandom);
            stall[0]                = ($urandom_range(0, 3) == 0);
            branch_flag_i           = ($urandom_range(0, 4) == 0);
            branch_target_address_i = $urandom;
            flush_i                 = ($urandom_range(0, 9) == 0);
            new_pc_i                = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            step();
            checks++;
            if (ce !== m_ce || pc !== m_pc || pend_valid_o !== m_pv ||
                misaligned_o !== (m_ce && (m_pc % INST_BYTES) != 0)) begin
                failures++;
                $display("FAIL random[%0d]: ce=%b pc=%h pend=%b mis=%b, want ce=%b pc=%h pend=%b mis=%b",
                         n, ce, pc, pend_valid_o, misaligned_o, m_ce, m_pc, m_pv,
                         (m_ce && (m_pc % INST_BYTES) != 0));
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        stall = 6'b000001;
        flush_i = 1'b1; new_pc_i = 32'h500;
        step();
        flush_i = 1'b0;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h600;
        step();
        idle_inputs();
        checks++;
        if (pc !== 32'h500 || pend_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: pc=%h pend=%b, want pc=00000500 pend=1", pc, pend_valid_o);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (ce !== 1'b0 || pc !== RESET_PC || pend_valid_o !== 1'b0 || misaligned_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: ce=%b pc=%h pend=%b mis=%b, want ce=0 pc=%h pend=0 mis=0",
                     ce, pc, pend_valid_o, misaligned_o, RESET_PC);
        end
        model_reset();
        step();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (ce !== 1'b1 || pc !== 32'h4 || pend_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reboot: ce=%b pc=%h pend=%b, want ce=1 pc=00000004 pend=0", ce, pc, pend_valid_o);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #2;
        test_reset();
        test_branch();
        test_stall_branch();
        test_flush_priority();
        test_wrap_misalign();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator for the openMIPS pipeline front end; drives the instruction-memory address and chip-enable.
- Next generation of the fetch PC register, adding:
  - configurable address width, reset vector and instruction step;
  - an exception/flush redirect input;
  - a one-entry pending-branch buffer, so a branch resolved while fetch is stalled is applied when the stall releases instead of being lost;
  - a misaligned-PC flag.

Parameters:
- ADDR_W, 32, width of pc, branch target and flush target.
- RESET_PC, 32'h0000_0000, first fetch address after reset (ADDR_W bits used).
- INST_BYTES, 4, sequential increment; power of two, range 1..8.
- STALL_W, 6, width of the pipeline stall vector; only bit 0 (fetch stage) is used here.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 holds fetch.
- branch_flag_i  in  1  branch taken, from decode.
- branch_target_address_i  in  ADDR_W  branch destination, valid when branch_flag_i=1.
- flush_i  in  1  exception/pipeline flush redirect.
- new_pc_i  in  ADDR_W  flush destination, valid when flush_i=1.
- ce  out  1  instruction-memory chip enable.
- pc  out  ADDR_W  current fetch address.
- pend_valid_o  out  1  pending branch held in buffer.
- misaligned_o  out  1  pc not INST_BYTES-aligned while ce=1.

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, ce=0, pc=RESET_PC, pend_valid=0, pend_addr=0.
- misaligned_o is combinational: ce & (pc[log2(INST_BYTES)-1:0]!=0). Its reset value is 0. It is constant 0 when INST_BYTES=1.
- State machine, two states:
  - BOOT: ce=0, pc held at RESET_PC; all inputs ignored. Next edge: go to RUN, ce<=1.
  - RUN: ce=1. Remains in RUN until reset.
- Latency from reset release: the first edge sets ce=1 with pc=RESET_PC, so RESET_PC is fetched. pc advances on the second edge.
- RUN, per rising edge, first matching rule wins:
  1. flush_i=1: pc<=new_pc_i; pend_valid<=0. Applies even when stall[0]=1 and even with branch_flag_i=1.
  2. stall[0]=1: pc held. If branch_flag_i=1, then pend_valid<=1 and pend_addr<=branch_target_address_i. A newer branch overwrites an older pending one. With no branch, the buffer is unchanged.
  3. stall[0]=0 and branch_flag_i=1: pc<=branch_target_address_i; pend_valid<=0. A live branch has priority over a stale pending one.
  4. stall[0]=0 and pend_valid=1: pc<=pend_addr; pend_valid<=0.
  5. Otherwise: pc<=pc+INST_BYTES, modulo 2^ADDR_W. All-ones region wraps to 0; no flag is raised.
- pc changes only on clock edges (registered, one-cycle latency from inputs). No combinational path from any input to pc or ce.
- Misaligned targets are loaded unchanged. They are reported only through misaligned_o; the exception stage handles them.
- Reset asserted mid-operation immediately returns all outputs to reset values and discards any pending branch.
- stall bits [STALL_W-1:1] are unused; lint waiver required.

Decomposition:
- Shared package/define file holds:
  - state encodings PC_BOOT/PC_RUN;
  - existing Branch, NoStop, ChipEnable, ChipDisable constants;
  - the new FlushEnable constant;
  - a localparam helper for log2(INST_BYTES).
- Sub-module pc_pend_buf: the one-entry pending-branch register, with set/clear/flush inputs, and outputs valid and addr. Everything else stays in pc_gen.

Test Plan:
1. Reset and boot:
   - Stimulus: hold rst=0 for 3 cycles, release, no stall, INST_BYTES=4.
   - Response: ce=0 and pc=0 during reset. ce=1 at edge 1 with pc=0x0. pc=0x4 at edge 2, then 0x8.
2. Branch with no stall:
   - Stimulus: pc=0x10, branch_flag_i=1, target=0x100 for one cycle.
   - Response: next pc=0x100, then 0x104.
3. Branch during stall:
   - Stimulus: pc=0x20, stall[0]=1 for 3 cycles, branch with target=0x200 in stall cycle 1.
   - Response: pc holds 0x20 and pend_valid_o=1 until stall drops. Next pc=0x200, then pend_valid_o=0 and pc=0x204.
4. Flush priority:
   - Stimulus: stall[0]=1, pending 0x200, then flush_i=1, new_pc_i=0x380 together with branch target 0x400.
   - Response: pc=0x380 and pend_valid_o=0. After the stall releases, pc=0x384.
5. Wrap and misalignment:
   - Stimulus: flush to 0xFFFF_FFFC.
   - Response: next pc=0x0000_0000.
   - Stimulus: branch to 0x102.
   - Response: pc=0x102, misaligned_o=1, next pc=0x106.
6. Asynchronous reset mid-operation:
   - Stimulus: drop rst between edges while pc=0x500 and pend_valid_o=1.
   - Response: ce=0, pc=RESET_PC, pend_valid_o=0 immediately, without waiting for a clock edge.
